// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and debounces raw A/B channels, then turns
// filtered Gray-code steps into one-clock Up/Down pulses (err on a double change).
module quad_decoder #(
  parameter int FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       A_in,
  input  logic       B_in,
  input  logic       en,
  output logic       Up,
  output logic       Down,
  output logic       err,
  output logic       ready,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    INIT = 3'd0,
    S00  = 3'd1,
    S10  = 3'd2,
    S11  = 3'd3,
    S01  = 3'd4
  } state_t;

  localparam logic [3:0] LAST = 4'(FILT_LEN - 1);

  // Channel vectors are packed {A, B}; index 1 is A, index 0 is B.
  logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0] cnt_q [2];
  logic [3:0] cnt_d [2];
  logic [1:0] filt_q, filt_d;
  logic [3:0] stab_q, stab_d;
  state_t     state_q, state_d;
  logic       up_q, up_d, down_q, down_d, err_q, err_d, ready_q, ready_d;

  function automatic state_t enc(input logic [1:0] ab);
    case (ab)
      2'b00:   enc = S00;
      2'b10:   enc = S10;
      2'b11:   enc = S11;
      default: enc = S01;
    endcase
  endfunction

  function automatic logic [1:0] dec(input state_t s);
    case (s)
      S10:     dec = 2'b10;
      S11:     dec = 2'b11;
      S01:     dec = 2'b01;
      default: dec = 2'b00;
    endcase
  endfunction

  // Forward rotation is A leading B: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    case (ab)
      2'b00:   fwd_next = 2'b10;
      2'b10:   fwd_next = 2'b11;
      2'b11:   fwd_next = 2'b01;
      default: fwd_next = 2'b00;
    endcase
  endfunction

  always_comb begin
    sync1_d = {A_in, B_in};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        // Accept on the clock the count would hit FILT_LEN; counter restarts.
        if (cnt_q[i] == LAST) filt_d[i] = sync2_q[i];
        else                  cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  always_comb begin
    logic [1:0] prev;
    logic [1:0] diff;
    state_d = state_q;
    stab_d  = stab_q;
    ready_d = ready_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    err_d   = 1'b0;
    prev    = dec(state_q);
    diff    = prev ^ filt_q;
    if (state_q == INIT) begin
      ready_d = 1'b0;
      if (sync2_q == filt_q) begin
        if (stab_q == LAST) begin
          state_d = enc(filt_q);
          ready_d = 1'b1;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + 4'd1;
        end
      end else begin
        stab_d = '0;
      end
    end else begin
      state_d = enc(filt_q);
      if (diff == 2'b11) begin
        err_d = en;
      end else if (diff != 2'b00) begin
        up_d   = en & (filt_q == fwd_next(prev));
        down_d = en & (filt_q != fwd_next(prev));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      filt_q  <= '0;
      stab_q  <= '0;
      state_q <= INIT;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      filt_q  <= filt_d;
      stab_q  <= stab_d;
      state_q <= state_d;
      up_q    <= up_d;
      down_q  <= down_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign Up        = up_q;
  assign Down      = down_q;
  assign err       = err_q;
  assign ready     = ready_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: expected pulses {cycle, kind} are queued
// at stimulus time and matched by a negedge monitor.
module tb_quad_decoder;

  localparam int FILT_LEN = 4;
  localparam int W = 18;
  localparam logic [1:0] C_UP = 2'd1, C_DN = 2'd2, C_ER = 2'd3;
  localparam logic [2:0] ST_INIT = 3'd0, ST_S00 = 3'd1, ST_S10 = 3'd2, ST_S11 = 3'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       A_in = 1'b0, B_in = 1'b0, en = 1'b1;
  logic       Up, Down, err, ready;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  quad_decoder #(.FILT_LEN(FILT_LEN)) dut (
    .clk(clk), .reset(reset), .A_in(A_in), .B_in(B_in), .en(en),
    .Up(Up), .Down(Down), .err(err), .ready(ready), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [1:0]   obs_code;
    logic [W-1:0] exp_v;
    if ($countones({Up, Down, err}) > 1) begin
      checks++;
      errors++;
      $display("FAIL pulse_exclusive cyc=%0d got Up=%b Down=%b err=%b want at most one high",
               cyc, Up, Down, err);
    end
    if (Up | Down | err) begin
      obs_code = Up ? C_UP : (Down ? C_DN : C_ER);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected cyc=%0d got code=%0d want no pulse", cyc, obs_code);
      end else begin
        exp_v = exp_q.pop_front();
        if ({16'(cyc), obs_code} !== exp_v) begin
          errors++;
          $display("FAIL pulse_match got cyc=%0d code=%0d want cyc=%0d code=%0d",
                   cyc, obs_code, exp_v[W-1:2], exp_v[1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; the next posedge is E0, pulse expected after edge E0+FILT_LEN+2.
  task automatic drive_step(input logic a, input logic b, input logic expect_pulse,
                            input logic [1:0] code, input int hold);
    A_in = a;
    B_in = b;
    if (expect_pulse) exp_q.push_back({16'(cyc + 1 + FILT_LEN + 2), code});
    repeat (hold) @(negedge clk);
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 60 && !ready; i++) @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout got ready=%b want 1", name, ready);
    end
  endtask

  task automatic do_reset(input logic a, input logic b);
    @(negedge clk);
    reset = 1'b0;
    A_in = a;
    B_in = b;
    en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_state(input string name, input logic [2:0] want);
    checks++;
    if (state_dbg !== want) begin
      errors++;
      $display("FAIL %s_state got %0d want %0d", name, state_dbg, want);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_pulses got %0d pending want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({Up, Down, err, ready} !== 4'b0000 || state_dbg !== ST_INIT) begin
      errors++;
      $display("FAIL reset_state got UDE_R=%b state=%0d want 0000 state=0",
               {Up, Down, err, ready}, state_dbg);
    end
    reset = 1'b1;
    wait_ready("reset");
    check_state("reset_s00", ST_S00);
    // Asynchronous assertion between clock edges must clear outputs at once.
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({Up, Down, err, ready} !== 4'b0000 || state_dbg !== ST_INIT) begin
      errors++;
      $display("FAIL reset_async got UDE_R=%b state=%0d want 0000 state=0",
               {Up, Down, err, ready}, state_dbg);
    end
  endtask

  task automatic test_init_11;
    do_reset(1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL init_ready_early got %b want 0", ready);
    end
    wait_ready("init");
    check_state("init_s11", ST_S11);
    repeat (10) @(negedge clk);
    check_drained("init");
  endtask

  task automatic test_forward;
    do_reset(1'b0, 1'b0);
    wait_ready("fwd");
    check_state("fwd_start", ST_S00);
    drive_step(1'b1, 1'b0, 1'b1, C_UP, 20);
    drive_step(1'b1, 1'b1, 1'b1, C_UP, 20);
    drive_step(1'b0, 1'b1, 1'b1, C_UP, 20);
    drive_step(1'b0, 1'b0, 1'b1, C_UP, 20);
    check_drained("fwd");
    check_state("fwd_end", ST_S00);
  endtask

  task automatic test_reverse;
    drive_step(1'b0, 1'b1, 1'b1, C_DN, 20);
    drive_step(1'b1, 1'b1, 1'b1, C_DN, 20);
    drive_step(1'b1, 1'b0, 1'b1, C_DN, 20);
    drive_step(1'b0, 1'b0, 1'b1, C_DN, 20);
    check_drained("rev");
    check_state("rev_end", ST_S00);
  endtask

  task automatic test_glitch;
    drive_step(1'b1, 1'b0, 1'b0, C_UP, FILT_LEN - 1);
    drive_step(1'b0, 1'b0, 1'b0, C_UP, 20);
    check_drained("glitch_short");
    check_state("glitch_short", ST_S00);
    drive_step(1'b1, 1'b0, 1'b1, C_UP, FILT_LEN);
    drive_step(1'b0, 1'b0, 1'b1, C_DN, 24);
    check_drained("glitch_exact");
    check_state("glitch_exact", ST_S00);
  endtask

  task automatic test_err;
    drive_step(1'b1, 1'b1, 1'b1, C_ER, 20);
    check_state("err_s11", ST_S11);
    drive_step(1'b0, 1'b0, 1'b1, C_ER, 20);
    check_state("err_s00", ST_S00);
    check_drained("err");
  endtask

  task automatic test_enable;
    en = 1'b0;
    drive_step(1'b1, 1'b0, 1'b0, C_UP, 20);
    check_state("en_track", ST_S10);
    en = 1'b1;
    drive_step(1'b1, 1'b1, 1'b1, C_UP, 20);
    check_state("en_s11", ST_S11);
    check_drained("en");
  endtask

  task automatic test_back_to_back;
    logic [1:0] seq [4];
    seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
    do_reset(1'b0, 1'b0);
    wait_ready("b2b");
    for (int i = 0; i < 8; i++) begin
      drive_step(seq[i % 4][1], seq[i % 4][0], 1'b1, C_UP, $urandom_range(FILT_LEN + 1, 9));
    end
    repeat (20) @(negedge clk);
    check_drained("b2b");
    check_state("b2b_end", ST_S00);
  endtask

  task automatic test_reset_mid;
    drive_step(1'b1, 1'b0, 1'b0, C_UP, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || state_dbg !== ST_INIT) begin
      errors++;
      $display("FAIL midreset_held got ready=%b state=%0d want 0 0", ready, state_dbg);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_recapture got ready=%b want 0", ready);
    end
    wait_ready("midreset");
    check_state("midreset_s10", ST_S10);
    repeat (20) @(negedge clk);
    check_drained("midreset");
  endtask

  initial begin
    test_reset();
    test_init_11();
    test_forward();
    test_reverse();
    test_glitch();
    test_err();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
